// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq #(
  parameter int W = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  if (W < 4 || W > 16 || DIGITS < 1 || DIGITS > 5) begin : g_bad_params
    $error("bin_to_bcd_seq: W must be 4..16 and DIGITS 1..5");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state;
  logic [W-1:0]  shreg;
  logic [BW-1:0] scratch, corr, nxt;
  logic [CW-1:0] cnt;
  logic          ovf_acc, carry;
  always_comb begin
    corr = scratch;
    for (int i = 0; i < DIGITS; i++)
      corr[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  // the bit leaving the top digit is worth 10^DIGITS, so dropping it yields bin mod 10^DIGITS
  assign carry = corr[BW-1];
  assign nxt = {corr[BW-2:0], shreg[W-1]};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          shreg   <= bin;
          scratch <= '0;
          cnt     <= CW'(W);
          ovf_acc <= 1'b0;
          busy    <= 1'b1;
          state   <= SHIFT;
        end
      end else begin
        shreg   <= shreg << 1;
        scratch <= nxt;
        ovf_acc <= ovf_acc | carry;
        cnt     <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd      <= nxt;
          overflow <= ovf_acc | carry;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of a 3-digit and a 2-digit converter driven in parallel
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy1, done1, ovf1, busy2, done2, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.W(8), .DIGITS(3)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
  );
  bin_to_bcd_seq #(.W(8), .DIGITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );
  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // launch from a negedge while idle; n counts negedges from the one after the accepting edge
  task automatic run(input logic [7:0] v, input logic [11:0] e3, input logic [7:0] e2,
                     input logic o2, input string tag);
    int n = 0, nb = 0;
    start = 1'b1; bin = v;
    @(negedge clk);
    start = 1'b0;
    while (!done1 && n < 30) begin
      nb += int'(busy1);
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " busy cycles"}, nb, 8);
    chk({tag, " busy with done"}, busy1, 0);
    chk({tag, " bcd3"}, bcd1, e3);
    chk({tag, " ovf3"}, ovf1, 0);
    chk({tag, " done2"}, done2, 1);
    chk({tag, " bcd2"}, bcd2, e2);
    chk({tag, " ovf2"}, ovf2, o2);
    @(negedge clk);
    chk({tag, " done pulse"}, done1, 0);
  endtask
  initial begin
    int n, nd;
    // 1: reset held with start high
    start = 1'b1; bin = 8'd55;
    repeat (2) @(negedge clk);
    chk("rst busy", busy1, 0);
    chk("rst done", done1, 0);
    chk("rst bcd", bcd1, 0);
    chk("rst ovf", ovf1, 0);
    chk("rst bcd2", bcd2, 0);
    start = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk("post rst idle", busy1, 0);
    // 2: basic conversions
    run(8'd255, 12'h255, 8'h55, 1'b1, "b255");
    run(8'd0, 12'h000, 8'h00, 1'b0, "b0");
    run(8'd99, 12'h099, 8'h99, 1'b0, "b99");
    // 3: exhaustive back-to-back, restarting in every done cycle
    start = 1'b1; bin = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!done1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("sweep %0d gap", i), n, 8);
      chk($sformatf("sweep %0d bcd", i), bcd1, bcd_of(i));
      chk($sformatf("sweep %0d bcd2", i), bcd2, bcd_of(i) & 12'h0ff);
      chk($sformatf("sweep %0d ovf2", i), ovf2, i >= 100);
      if (i < 255) begin
        start = 1'b1; bin = 8'(i + 1);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("sweep %0d restart busy", i), busy1, 1);
      end
    end
    @(negedge clk);
    // 4: start while busy is ignored
    start = 1'b1; bin = 8'd42;
    @(negedge clk);
    start = 1'b0; bin = 8'd0;
    repeat (2) @(negedge clk);
    start = 1'b1; bin = 8'd17;
    @(negedge clk);
    start = 1'b0; bin = 8'hAA;
    n = 3;
    while (!done1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ign latency", n, 8);
    chk("ign bcd", bcd1, 12'h042);
    chk("ign bcd2", bcd2, 8'h42);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(done1) + int'(busy1);
    end
    chk("ign no second run", nd, 0);
    // 5: reset mid-conversion
    start = 1'b1; bin = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst busy", busy1, 0);
    chk("midrst bcd", bcd1, 0);
    chk("midrst bcd2", bcd2, 0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      nd += int'(done1);
    end
    chk("midrst no done", nd, 0);
    run(8'd7, 12'h007, 8'h07, 1'b0, "b7");
    // 6: two-digit overflow sets, then clears on the next result
    run(8'd255, 12'h255, 8'h55, 1'b1, "ovf255");
    run(8'd99, 12'h099, 8'h99, 1'b0, "ovf99");
    run(8'd100, 12'h100, 8'h00, 1'b1, "ovf100");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
